// File: rtl/rs_chien_search_if.sv
// Handshake and result bundle between the key-equation solver, the Chien
// search stage and the Forney stage of the RS(255,247) decoder.
interface rs_chien_search_if;
  logic       start;
  logic [2:0] elp_deg;
  logic [7:0] lambda1;
  logic [7:0] lambda2;
  logic [7:0] lambda3;
  logic [7:0] lambda4;
  logic [2:0] error_num;
  logic [7:0] el1;
  logic [7:0] el2;
  logic [7:0] el3;
  logic [7:0] el4;
  logic [7:0] loc1;
  logic [7:0] loc2;
  logic [7:0] loc3;
  logic [7:0] loc4;
  logic       fail;
  logic       done;

  modport master (
    output start, elp_deg, lambda1, lambda2, lambda3, lambda4,
    input  error_num, el1, el2, el3, el4, loc1, loc2, loc3, loc4, fail, done
  );

  modport slave (
    input  start, elp_deg, lambda1, lambda2, lambda3, lambda4,
    output error_num, el1, el2, el3, el4, loc1, loc2, loc3, loc4, fail, done
  );
endinterface

// File: rtl/rs_chien_search.sv
// Chien search for RS(255,247) over GF(2^8), p(x)=0x11D: evaluates the error
// locator at alpha^1..alpha^255, one element per clock, and records the roots.
module rs_chien_search (
  input logic             clk,
  input logic             rst_n,
  rs_chien_search_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

  state_t     state, state_nx;
  logic [7:0] term1, term2, term3, term4;
  logic [7:0] x_q;
  logic [7:0] step_q;
  logic [7:0] pos_q;
  logic [2:0] deg_q;
  logic [2:0] cnt_q;
  logic [7:0] el_q  [4];
  logic [7:0] loc_q [4];
  logic       fail_q;

  logic       accept;
  logic       short_run;
  logic       last_step;
  logic [7:0] sum;
  logic       hit;
  logic [2:0] cnt_nx;

  function automatic logic [7:0] mul_a1(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] mul_a2(input logic [7:0] a);
    return mul_a1(mul_a1(a));
  endfunction

  function automatic logic [7:0] mul_a3(input logic [7:0] a);
    return mul_a1(mul_a2(a));
  endfunction

  function automatic logic [7:0] mul_a4(input logic [7:0] a);
    return mul_a2(mul_a2(a));
  endfunction

  assign accept    = (state == IDLE) && bus.start;
  assign short_run = (bus.elp_deg == 3'd0) || (bus.elp_deg > 3'd4);
  assign last_step = (step_q == 8'd255);
  assign sum       = 8'h01 ^ term1 ^ term2 ^ term3 ^ term4;
  assign hit       = (sum == 8'h00);
  // Root count saturates so a runaway locator cannot wrap back to a valid count.
  assign cnt_nx    = (hit && (cnt_q != 3'd7)) ? cnt_q + 3'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = short_run ? FINISH : SEARCH;
      SEARCH:  if (last_step) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term1  <= '0;
      term2  <= '0;
      term3  <= '0;
      term4  <= '0;
      x_q    <= '0;
      step_q <= '0;
      pos_q  <= '0;
      deg_q  <= '0;
      cnt_q  <= '0;
      fail_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        el_q[k]  <= '0;
        loc_q[k] <= '0;
      end
    end else if (accept) begin
      term1  <= mul_a1(bus.lambda1);
      term2  <= mul_a2(bus.lambda2);
      term3  <= mul_a3(bus.lambda3);
      term4  <= mul_a4(bus.lambda4);
      x_q    <= 8'h02;
      step_q <= 8'd1;
      pos_q  <= 8'd254;
      deg_q  <= bus.elp_deg;
      cnt_q  <= '0;
      // Degenerate degrees skip the search, so their verdict is known now.
      fail_q <= (bus.elp_deg > 3'd4);
      for (int k = 0; k < 4; k++) begin
        el_q[k]  <= '0;
        loc_q[k] <= '0;
      end
    end else if (state == SEARCH) begin
      if (hit && (cnt_q < 3'd4)) begin
        el_q[cnt_q[1:0]]  <= x_q;
        loc_q[cnt_q[1:0]] <= pos_q;
      end
      cnt_q  <= cnt_nx;
      term1  <= mul_a1(term1);
      term2  <= mul_a2(term2);
      term3  <= mul_a3(term3);
      term4  <= mul_a4(term4);
      x_q    <= mul_a1(x_q);
      step_q <= step_q + 8'd1;
      if (!last_step) pos_q <= pos_q - 8'd1;
      // Verdict is registered on the way into FINISH so it is valid alongside done.
      if (last_step) fail_q <= (deg_q > 3'd4) || (cnt_nx != deg_q);
    end
  end

  assign bus.error_num = cnt_q;
  assign bus.el1       = el_q[0];
  assign bus.el2       = el_q[1];
  assign bus.el3       = el_q[2];
  assign bus.el4       = el_q[3];
  assign bus.loc1      = loc_q[0];
  assign bus.loc2      = loc_q[1];
  assign bus.loc3      = loc_q[2];
  assign bus.loc4      = loc_q[3];
  assign bus.fail      = fail_q;
  assign bus.done      = (state == FINISH);

endmodule

// File: tb/tb_rs_chien_search.sv
// Scoreboard bench for rs_chien_search: a polynomial-evaluation reference model
// predicts roots, positions, verdict and done latency for each accepted start.
module tb_rs_chien_search;

  typedef struct packed {
    logic [2:0]       cnt;
    logic             fail;
    logic [3:0][7:0]  el;
    logic [3:0][7:0]  loc;
    logic [31:0]      lat;
    logic [31:0]      t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  rs_chien_search_if bus();

  rs_chien_search dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011D << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] apow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < e; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // Evaluates Lambda at every alpha^i directly and lists roots in ascending i.
  function automatic exp_t model(input logic [7:0] l1, input logic [7:0] l2,
                                 input logic [7:0] l3, input logic [7:0] l4,
                                 input logic [2:0] deg);
    exp_t e;
    logic [7:0] x, x2, x3, x4, v;
    int cnt;
    e = '0;
    cnt = 0;
    if (deg >= 1 && deg <= 4) begin
      for (int i = 1; i <= 255; i++) begin
        x  = apow(i);
        x2 = gmul(x, x);
        x3 = gmul(x2, x);
        x4 = gmul(x3, x);
        v  = 8'h01 ^ gmul(l1, x) ^ gmul(l2, x2) ^ gmul(l3, x3) ^ gmul(l4, x4);
        if (v == 8'h00) begin
          if (cnt < 4) begin
            e.el[cnt]  = x;
            e.loc[cnt] = 8'(255 - i);
          end
          if (cnt < 7) cnt++;
        end
      end
      e.lat = 256;
    end else begin
      e.lat = 1;
    end
    e.cnt  = 3'(cnt);
    e.fail = (deg > 4) || (cnt != int'(deg));
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency",   32'(cyc) - mon_e.t0, mon_e.lat);
        chk("error_num", 32'(bus.error_num), 32'(mon_e.cnt));
        chk("fail",      32'(bus.fail), 32'(mon_e.fail));
        chk("el1",  32'(bus.el1),  32'(mon_e.el[0]));
        chk("el2",  32'(bus.el2),  32'(mon_e.el[1]));
        chk("el3",  32'(bus.el3),  32'(mon_e.el[2]));
        chk("el4",  32'(bus.el4),  32'(mon_e.el[3]));
        chk("loc1", 32'(bus.loc1), 32'(mon_e.loc[0]));
        chk("loc2", 32'(bus.loc2), 32'(mon_e.loc[1]));
        chk("loc3", 32'(bus.loc3), 32'(mon_e.loc[2]));
        chk("loc4", 32'(bus.loc4), 32'(mon_e.loc[3]));
      end
    end
  end

  task automatic drive(input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] l3,
                       input logic [7:0] l4, input logic [2:0] deg, input bit expect_run);
    exp_t e;
    @(negedge clk);
    bus.lambda1 = l1;
    bus.lambda2 = l2;
    bus.lambda3 = l3;
    bus.lambda4 = l4;
    bus.elp_deg = deg;
    bus.start   = 1'b1;
    if (expect_run) begin
      e = model(l1, l2, l3, l4, deg);
      e.t0 = 32'(cyc);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.lambda1 = 8'($urandom_range(0, 255));
    bus.lambda2 = 8'($urandom_range(0, 255));
    bus.lambda3 = 8'($urandom_range(0, 255));
    bus.lambda4 = 8'($urandom_range(0, 255));
    bus.elp_deg = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [7:0] l1, input logic [7:0] l2, input logic [7:0] l3,
                     input logic [7:0] l4, input logic [2:0] deg);
    drive(l1, l2, l3, l4, deg, 1'b1);
    wait_done();
  endtask

  task automatic run_roots(input int d);
    logic [7:0] c[5];
    int pos[4];
    bit dup;
    logic [7:0] xr;
    c[0] = 8'h01;
    for (int j = 1; j < 5; j++) c[j] = 8'h00;
    for (int k = 0; k < d; k++) begin
      do begin
        pos[k] = $urandom_range(0, 254);
        dup = 1'b0;
        for (int m = 0; m < k; m++) if (pos[m] == pos[k]) dup = 1'b1;
      end while (dup);
      xr = apow(pos[k]);
      for (int j = k + 1; j >= 1; j--) c[j] = c[j] ^ gmul(c[j-1], xr);
    end
    run(c[1], c[2], c[3], c[4], 3'(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.elp_deg = '0;
    bus.lambda1 = '0;
    bus.lambda2 = '0;
    bus.lambda3 = '0;
    bus.lambda4 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_done",      32'(bus.done), 32'd0);
    chk("rst_fail",      32'(bus.fail), 32'd0);
    chk("rst_error_num", 32'(bus.error_num), 32'd0);
    chk("rst_el1",       32'(bus.el1), 32'd0);
    chk("rst_loc4",      32'(bus.loc4), 32'd0);

    run(8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
    run(8'h8E, 8'h00, 8'h00, 8'h00, 3'd1);
    run(8'h01, 8'h00, 8'h00, 8'h00, 3'd1);
    run(8'h7C, 8'h87, 8'h00, 8'h00, 3'd2);
    run(8'h8E, 8'h00, 8'h00, 8'h00, 3'd2);
    run(8'h8E, 8'h00, 8'h00, 8'h00, 3'd5);

    // A start during the FINISH cycle must not launch a run.
    bus.start   = 1'b1;
    bus.elp_deg = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a search: outputs clear, no done follows.
    drive(8'h7C, 8'h87, 8'h00, 8'h00, 3'd2, 1'b0);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_error_num", 32'(bus.error_num), 32'd0);
    chk("abort_el1",       32'(bus.el1), 32'd0);
    chk("abort_loc2",      32'(bus.loc2), 32'd0);
    chk("abort_done",      32'(bus.done), 32'd0);
    chk("abort_fail",      32'(bus.fail), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    run(8'h7C, 8'h87, 8'h00, 8'h00, 3'd2);

    // A start pulse mid-search is ignored.
    drive(8'h8E, 8'h00, 8'h00, 8'h00, 3'd1, 1'b1);
    repeat (50) @(negedge clk);
    bus.start   = 1'b1;
    bus.elp_deg = 3'd0;
    bus.lambda1 = 8'h01;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    for (int r = 0; r < 12; r++) run_roots($urandom_range(1, 4));
    for (int r = 0; r < 6; r++)
      run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          3'($urandom_range(0, 7)));

    repeat (5) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_chien_search.md
# rs_chien_search

Chien search stage of the RS(255,247) decoder. It sits between the key-equation solver and the Forney stage. It takes the error-locator polynomial Λ(x) = 1 + λ1·x + λ2·x² + λ3·x³ + λ4·x⁴ and its claimed degree, and evaluates Λ at every nonzero field element, one element per clock. It produces the roots (el1..el4 for Forney), the matching codeword symbol positions, the error count, and a decode-failure flag.

## Interface
- No parameters. Field is GF(2^8), p(x)=0x11D, α=0x02, identical to gf256mul.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- elp_deg  in  3  degree of Λ from the solver (0..7)
- lambda1..lambda4  in  8 each  Λ coefficients; sampled on accepted start
- error_num  out  3  number of roots found
- el1..el4  out  8 each  roots of Λ in discovery order; unused slots 0
- loc1..loc4  out  8 each  symbol position p of each root (254 = first transmitted symbol); unused slots 0
- fail  out  1  uncorrectable: error_num ≠ elp_deg, or elp_deg > 4
- done  out  1  one-cycle pulse; outputs valid from this cycle until the next accepted start

## Operation
- States: IDLE, SEARCH, FINISH.
- IDLE, start=1, elp_deg=0:
  - clear all result registers (el*, loc*, error_num=0, fail=0);
  - go to FINISH; no search runs.
- IDLE, start=1, elp_deg>4:
  - clear result registers; go to FINISH;
  - fail=1 is set at FINISH.
- IDLE, start=1, elp_deg 1..4:
  - clear result registers;
  - load term_j ← λj·α^j (j=1..4; constant multiplies by α, α², α³, α⁴ using gf256mul instances);
  - load x ← 0x02, step counter i ← 1, pos ← 254;
  - go to SEARCH.
- Each SEARCH cycle:
  - compute sum = 0x01 ^ term1 ^ term2 ^ term3 ^ term4 (combinational).
  - If sum==0 and fewer than 4 roots are stored: write x into slot el[error_num+1], write pos into the matching loc slot, and increment error_num.
  - Update term_j ← term_j·α^j, x ← x·α, i ← i+1, pos ← pos−1.
- A root at x=α^i corresponds to symbol position p = 255−i. el_k = α^(−p_k), which is the form Forney consumes.
- SEARCH runs exactly 255 cycles (i = 1..255). Step i=255 evaluates x=0x01, i.e. position 0. The pos arithmetic is 8-bit and must not wrap below 0 during the search. Then go to FINISH.
- FINISH:
  - fail ← (elp_deg>4) | (error_num≠elp_deg);
  - done=1 for this cycle;
  - return to IDLE.
- A 5th root cannot occur when degree ≤ 4. If one does, the slot write is suppressed and fail is still computed from the count. The count register saturates at 7.
- start outside IDLE is ignored. Inputs may change after the start cycle.
- Λ(0)=1, so x=0 is never a root and is never evaluated.

## Timing
- Reset: state=IDLE; done=0; fail=0; error_num=0; el1..el4=0; loc1..loc4=0; all internal registers 0.
- Start accepted at cycle 0. SEARCH occupies cycles 1..255, and cycle k evaluates α^k. done and final fail are asserted in cycle 256.
- With elp_deg=0 or >4, done is asserted at cycle 1.
- Root registers update at the end of the SEARCH cycle that evaluates the root. error_num is visibly incremental during the search; consumers use it only when done=1.
- rst_n asserted mid-search: immediate return to reset values, and no done pulse. After release, the block waits for a new start.
- start in the FINISH cycle is ignored. The earliest new start is the cycle after done.

## Test plan
- elp_deg=0, start → done at cycle 1, error_num=0, fail=0, all el/loc=0.
- Single error at position 254: λ1=α^254=0x8E, others 0, elp_deg=1 → done at cycle 256, error_num=1, el1=0x02, loc1=254, fail=0.
- Single error at position 0: λ1=0x01, elp_deg=1 → root found at SEARCH step 255, el1=0x01, loc1=0, fail=0.
- Errors at positions 10 and 3: λ1=0x7C, λ2=0x87 (α^13), elp_deg=2 → error_num=2, el1=α^245 with loc1=10, el2=α^252 with loc2=3, fail=0.
- Degree mismatch: λ1=0x8E, λ2=0, elp_deg=2 → error_num=1, fail=1. Separately, elp_deg=5 → done at cycle 1, fail=1.
- Reset and busy handling:
  - rst_n pulled low at SEARCH step 100 → all outputs return to 0 and no done pulse; a fresh run then completes normally.
  - A start pulse during SEARCH leaves results and timing unchanged.
